// File: rtl/gcm_pkg.sv
// Shared GF(2^128) constants and FSM state encoding for the GCM multiplier.
`default_nettype none
package gcm_pkg;
  localparam int BLOCK_W = 128;
  localparam logic [0:BLOCK_W-1] GF_R = {8'hE1, 120'd0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/gfmul_digit_step.sv
// One combinational DIGIT-bit step of the bit-serial GCM multiply (bit 0 first).
`default_nettype none
module gfmul_digit_step
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [0:BLOCK_W-1] z,
  input  logic [0:BLOCK_W-1] v,
  input  logic [0:DIGIT-1]   xbits,
  output logic [0:BLOCK_W-1] z_next,
  output logic [0:BLOCK_W-1] v_next
);

  always_comb begin
    z_next = z;
    v_next = v;
    for (int i = 0; i < DIGIT; i++) begin
      z_next = z_next ^ (v_next & {BLOCK_W{xbits[i]}});
      // Right shift in GCM bit order moves x^k toward x^(k+1); reduce on overflow
      v_next = (v_next >> 1) ^ (GF_R & {BLOCK_W{v_next[BLOCK_W-1]}});
    end
  end

endmodule
`default_nettype wire

// File: rtl/gfmul_digit.sv
// Digit-serial GF(2^128) multiplier with GHASH accumulator and valid/ready handshake.
`default_nettype none
module gfmul_digit
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iValid,
  output logic               oReady,
  input  logic [0:BLOCK_W-1] iCtext,
  input  logic [0:BLOCK_W-1] iHashkey,
  input  logic               iAccum,
  input  logic               iClear,
  output logic               oValid,
  input  logic               iReady,
  output logic [0:BLOCK_W-1] oResult
);

  localparam int NCYC  = BLOCK_W / DIGIT;
  localparam int CNT_W = $clog2(NCYC) + 1;

  generate
    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 ||
          DIGIT == 16 || DIGIT == 32 || DIGIT == 64 || DIGIT == 128)) begin : g_bad_digit
      $error("gfmul_digit: DIGIT must be a power of two between 1 and 128");
    end
  endgenerate

  state_t             state;
  logic [0:BLOCK_W-1] x;
  logic [0:BLOCK_W-1] z;
  logic [0:BLOCK_W-1] v;
  logic [0:BLOCK_W-1] y;
  logic               acc;
  logic [CNT_W-1:0]   cnt;
  logic [0:BLOCK_W-1] z_step;
  logic [0:BLOCK_W-1] v_step;

  gfmul_digit_step #(
    .DIGIT(DIGIT)
  ) u_step (
    .z     (z),
    .v     (v),
    .xbits (x[0:DIGIT-1]),
    .z_next(z_step),
    .v_next(v_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      oReady  <= 1'b1;
      oValid  <= 1'b0;
      oResult <= '0;
      x       <= '0;
      z       <= '0;
      v       <= '0;
      y       <= '0;
      acc     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            x      <= iAccum ? (iCtext ^ (iClear ? '0 : y)) : iCtext;
            v      <= iHashkey;
            z      <= '0;
            cnt    <= '0;
            acc    <= iAccum;
            oReady <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(NCYC)) begin
            oResult <= z;
            oValid  <= 1'b1;
            state   <= DONE;
          end else begin
            z   <= z_step;
            v   <= v_step;
            // Consumed multiplier bits shift out so the next digit is always x[0:DIGIT-1]
            x   <= x << DIGIT;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            oReady <= 1'b1;
            state  <= IDLE;
            if (acc) y <= oResult;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gfmul_digit.sv
// Scoreboard bench running DIGIT=1, 8 and 128 instances side by side on shared stimulus.
`default_nettype none
module tb_gfmul_digit;

  localparam logic [0:127] RPOLY = {8'hE1, 120'd0};
  localparam logic [0:127] HKEY  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         iValid = 1'b0;
  logic         iAccum = 1'b0;
  logic         iClear = 1'b0;
  logic         iReady = 1'b1;
  logic [0:127] iCtext = '0;
  logic [0:127] iHashkey = '0;

  logic         rdy [3];
  logic         ov  [3];
  logic [0:127] res [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      gfmul_digit #(
        .DIGIT(g == 0 ? 1 : (g == 1 ? 8 : 128))
      ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iValid  (iValid),
        .oReady  (rdy[g]),
        .iCtext  (iCtext),
        .iHashkey(iHashkey),
        .iAccum  (iAccum),
        .iClear  (iClear),
        .oValid  (ov[g]),
        .iReady  (iReady),
        .oResult (res[g])
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [0:127] q0[$];
  logic [0:127] q1[$];
  logic [0:127] q2[$];
  logic [0:127] y_m = '0;
  int           rise [3];
  bit           seen [3];

  function automatic int ncyc(input int k);
    return (k == 0) ? 128 : ((k == 1) ? 16 : 1);
  endfunction

  function automatic logic [0:127] gf_mult(input logic [0:127] a, input logic [0:127] b);
    logic [0:127] zz;
    logic [0:127] vv;
    logic         lsb;
    zz = '0;
    vv = b;
    for (int i = 0; i < 128; i++) begin
      if (a[i]) zz = zz ^ vv;
      lsb = vv[127];
      vv  = vv >> 1;
      if (lsb) vv = vv ^ RPOLY;
    end
    return zz;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: one expected entry per DUT is retired on each output transfer
  always @(negedge clk) begin : mon
    logic [0:127] e;
    bit           have;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k] && !seen[k]) begin
          seen[k] = 1'b1;
          rise[k] = cyc;
        end
        if (ov[k] && iReady) begin
          have = 1'b1;
          e    = '0;
          case (k)
            0: if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
          endcase
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL scoreboard_unexpected dut%0d got %h with nothing expected", k, res[k]);
          end else if (res[k] !== e) begin
            errors++;
            $display("FAIL scoreboard dut%0d got %h expected %h", k, res[k], e);
          end
        end
      end
    end
  end

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL wait_idle timeout ready=%b%b%b expected 111", rdy[0], rdy[1], rdy[2]);
    end
  endtask

  task automatic send(input logic [0:127] x, input logic [0:127] h, input logic accum,
                      input logic clear, output int acc_cyc);
    logic [0:127] xp;
    logic [0:127] e;
    wait_idle(400);
    xp = accum ? (x ^ (clear ? 128'd0 : y_m)) : x;
    e  = gf_mult(xp, h);
    q0.push_back(e);
    q1.push_back(e);
    q2.push_back(e);
    if (accum) y_m = e;
    for (int k = 0; k < 3; k++) seen[k] = 1'b0;
    iCtext   = x;
    iHashkey = h;
    iAccum   = accum;
    iClear   = clear;
    iValid   = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    iValid   = 1'b0;
    // Scramble operands after accept; the result must not depend on them
    iCtext   = rnd128();
    iHashkey = rnd128();
    iAccum   = ~accum;
    iClear   = ~clear;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    iValid = 1'b0;
    iReady = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid dut%0d got %b expected 0", k, ov[k]);
      end
      checks++;
      if (res[k] !== 128'd0) begin
        errors++;
        $display("FAIL reset_result dut%0d got %h expected 0", k, res[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready dut%0d got %b expected 1", k, rdy[k]);
      end
    end
  endtask

  task automatic test_unity();
    int acc;
    send(128'h80000000000000000000000000000000, HKEY, 1'b0, 1'b0, acc);
    wait_idle(400);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rise[k] !== acc + ncyc(k) + 1) begin
        errors++;
        $display("FAIL latency dut%0d got %0d expected %0d", k, rise[k] - acc, ncyc(k) + 1);
      end
      checks++;
      if (res[k] !== HKEY) begin
        errors++;
        $display("FAIL unity dut%0d got %h expected %h", k, res[k], HKEY);
      end
    end
  endtask

  task automatic test_ghash();
    int acc;
    send(128'h0388dace60b6a392f328c2b971b2fe78, HKEY, 1'b1, 1'b1, acc);
    wait_idle(400);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (res[k] !== 128'h5e2ec746917062882c85b0685353deb7) begin
        errors++;
        $display("FAIL ghash_step1 dut%0d got %h expected 5e2ec746917062882c85b0685353deb7", k, res[k]);
      end
    end
    send(128'h00000000000000000000000000000080, HKEY, 1'b1, 1'b0, acc);
    wait_idle(400);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (res[k] !== 128'hf38cbb1ad69223dcc3457ae5b6b0f885) begin
        errors++;
        $display("FAIL ghash_step2 dut%0d got %h expected f38cbb1ad69223dcc3457ae5b6b0f885", k, res[k]);
      end
      checks++;
      if (rise[k] !== acc + ncyc(k) + 1) begin
        errors++;
        $display("FAIL ghash_latency dut%0d got %0d expected %0d", k, rise[k] - acc, ncyc(k) + 1);
      end
    end
  endtask

  task automatic test_stall();
    int           acc;
    int           n;
    logic [0:127] x;
    logic [0:127] h;
    logic [0:127] e;
    x = rnd128();
    h = rnd128();
    e = gf_mult(x, h);
    iReady = 1'b0;
    send(x, h, 1'b0, 1'b0, acc);
    n = 0;
    while (!(ov[0] && ov[1] && ov[2]) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL stall_wait timeout valid=%b%b%b expected 111", ov[0], ov[1], ov[2]);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      iCtext = rnd128();
      iValid = ~iValid;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (res[k] !== e || ov[k] !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold dut%0d got %h/%b expected %h/1", k, res[k], ov[k], e);
        end
        checks++;
        if (rdy[k] !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready dut%0d got %b expected 0", k, rdy[k]);
        end
      end
    end
    iValid = 1'b0;
    iReady = 1'b1;
    @(negedge clk);
    wait_idle(400);
  endtask

  task automatic test_reset_busy();
    int           acc;
    bit           bad;
    logic [0:127] xl;
    logic [0:127] e;
    send(rnd128(), HKEY, 1'b1, 1'b1, acc);
    wait_idle(400);
    send(rnd128(), HKEY, 1'b1, 1'b0, acc);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    y_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ov[0] || ov[1] || ov[2]) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_busy_valid got 1 expected 0");
    end
    xl = 128'h00000000000000000000000000000080;
    e  = gf_mult(xl, HKEY);
    send(xl, HKEY, 1'b1, 1'b0, acc);
    wait_idle(400);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (res[k] !== e) begin
        errors++;
        $display("FAIL reset_busy_result dut%0d got %h expected %h", k, res[k], e);
      end
    end
  endtask

  task automatic test_random();
    int acc;
    iReady = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(rnd128(), rnd128(), 1'b0, 1'b0, acc);
    end
    wait_idle(400);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unity();
    test_ghash();
    test_stall();
    test_reset_busy();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d/%0d pending expected 0", q0.size(), q1.size(), q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
